lifo_stack: RTL and testbench

//  Parametrised LIFO for the maze-solver datapath. It stores move codes,

---
 rtl/lifo_stack_pkg.sv | 34 +++
 rtl/lifo_stack_ram.sv | 23 ++
 rtl/lifo_stack.sv | 80 ++++++++
 tb/tb_lifo_stack.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the maze-solver LIFO: default geometry, move codes
// and the per-cycle operation decode used by lifo_stack.
package lifo_stack_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_DEPTH  = 256;

  localparam logic [1:0] MOVE_UP    = 2'd0;
  localparam logic [1:0] MOVE_RIGHT = 2'd1;
  localparam logic [1:0] MOVE_DOWN  = 2'd2;
  localparam logic [1:0] MOVE_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } stack_op_e;

  // Clear wins; push+pop on an empty stack degrades to a plain push.
  function automatic stack_op_e decode_op(input logic clr, input logic push,
                                          input logic pop, input logic empty,
                                          input logic full);
    if (clr)              return OP_CLR;
    else if (push && pop) return empty ? OP_PUSH : OP_REPLACE;
    else if (push)        return full ? OP_OVERFLOW : OP_PUSH;
    else if (pop)         return empty ? OP_UNDERFLOW : OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module stack_ram #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO with count, full/empty flags, push+pop replace,
// registered overflow/underflow pulses and synchronous clear.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_empty;
  logic              w_full;
  stack_op_e         w_op;
  logic [AW-1:0]     w_top_idx;
  logic [AW-1:0]     w_waddr;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_op      = decode_op(clr, push, pop, w_empty, w_full);
  // Top index is meaningless when empty; every consumer is gated by w_empty.
  assign w_top_idx = AW'(r_count - CNT_W'(1));
  assign w_we      = (w_op == OP_PUSH) || (w_op == OP_REPLACE);
  assign w_waddr   = (w_op == OP_REPLACE) ? w_top_idx : AW'(r_count);

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (din),
    .raddr (w_top_idx),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (w_op == OP_OVERFLOW);
      r_underflow <= (w_op == OP_UNDERFLOW);
      case (w_op)
        OP_CLR:  r_count <= '0;
        OP_PUSH: r_count <= r_count + CNT_W'(1);
        OP_POP:  r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout      = w_empty ? '0 : w_rdata;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed and random checks of lifo_stack against a queue-based model.
module tb_lifo_stack;

  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_q[$];
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;

  lifo_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] exp_dout;
    exp_dout = (model_q.size() == 0) ? 32'd0 : 32'(model_q[model_q.size()-1]);
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    chk({tag, "_dout"},  32'(dout),  exp_dout);
    chk({tag, "_ovf"},   32'(overflow),  32'(exp_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(exp_unf));
  endtask

  // Stack semantics expressed directly on a queue: back of queue is the top.
  task automatic model_step(input logic c, input logic pu, input logic po,
                            input logic [DATA_W-1:0] d);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (c) begin
      model_q.delete();
    end else if (pu && po) begin
      if (model_q.size() != 0) void'(model_q.pop_back());
      model_q.push_back(d);
    end else if (pu) begin
      if (model_q.size() == DEPTH) exp_ovf = 1'b1;
      else model_q.push_back(d);
    end else if (po) begin
      if (model_q.size() == 0) exp_unf = 1'b1;
      else void'(model_q.pop_back());
    end
  endtask

  // Called at a negedge: drive, take one posedge, check at the next negedge.
  task automatic step(input string tag, input logic c, input logic pu,
                      input logic po, input logic [DATA_W-1:0] d);
    clr = c; push = pu; pop = po; din = d;
    @(posedge clk);
    model_step(c, pu, po, d);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset state before any clock edge
    #2;
    chk_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("rst_rel");

    // Push order and pop
    step("p1", 1'b0, 1'b1, 1'b0, 2'd1);
    step("p2", 1'b0, 1'b1, 1'b0, 2'd2);
    step("p3", 1'b0, 1'b1, 1'b0, 2'd3);
    chk("t2_dout3", 32'(dout), 32'd3);
    chk("t2_cnt3",  32'(count), 32'd3);
    step("pop1", 1'b0, 1'b0, 1'b1, '0);
    step("pop2", 1'b0, 1'b0, 1'b1, '0);
    chk("t2_dout1", 32'(dout), 32'd1);
    chk("t2_cnt1",  32'(count), 32'd1);

    // Fill to full, then overflow
    step("f2", 1'b0, 1'b1, 1'b0, 2'd2);
    step("f3", 1'b0, 1'b1, 1'b0, 2'd0);
    step("f4", 1'b0, 1'b1, 1'b0, 2'd3);
    chk("t3_full", 32'(full), 32'd1);
    step("ovf", 1'b0, 1'b1, 1'b0, 2'd1);
    chk("t3_ovf_pulse", 32'(overflow), 32'd1);
    chk("t3_ovf_dout",  32'(dout), 32'd3);
    idle("ovf_clr");
    chk("t3_ovf_gone", 32'(overflow), 32'd0);
    step("repl_full", 1'b0, 1'b1, 1'b1, 2'd2);

    // Clear with push asserted
    step("pre_clr", 1'b0, 1'b0, 1'b1, '0);
    step("clr", 1'b1, 1'b1, 1'b0, 2'd1);
    chk("t6_empty", 32'(empty), 32'd1);

    // Underflow and push+pop on empty
    step("unf", 1'b0, 1'b0, 1'b1, '0);
    chk("t4_unf_pulse", 32'(underflow), 32'd1);
    step("unf2", 1'b0, 1'b0, 1'b1, '0);
    idle("unf_clr");
    step("pp_empty", 1'b0, 1'b1, 1'b1, 2'd2);
    chk("t4_pp_dout", 32'(dout), 32'd2);

    // Replace top: count=2, top=3 -> din=0
    step("r_push", 1'b0, 1'b1, 1'b0, 2'd3);
    step("repl", 1'b0, 1'b1, 1'b1, 2'd0);
    chk("t5_dout0", 32'(dout), 32'd0);
    step("repl_pop", 1'b0, 1'b0, 1'b1, '0);
    chk("t5_below", 32'(dout), 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 3)));
    end

    // Mid-cycle asynchronous reset with a populated stack
    step("m1", 1'b0, 1'b1, 1'b0, 2'd1);
    step("m2", 1'b0, 1'b1, 1'b0, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("arst_rel");
    step("arst_push", 1'b0, 1'b1, 1'b0, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
